// File: rtl/pc_step_controller.sv
// Sequencer in front of the program counter: turns a debounced step button or free-run
// enable into single-cycle nxt pulses, steers branch overrides and latches hang/alignment faults.
module pc_step_controller #(
  parameter int ADDR_W          = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_btn,
  input  logic              run_en,
  input  logic              halt_req,
  input  logic              exec_done,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              nxt,
  output logic              override_en,
  output logic [ADDR_W-1:0] override_pc,
  output logic              busy,
  output logic              fault,
  output logic [15:0]       issue_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic              sync1, sync2;
  logic              db_level, db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic              step_evt;
  logic [1:0]        state;
  logic [TO_W-1:0]   to_cnt;
  logic              pend_br;
  logic [ADDR_W-1:0] pend_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
    end
  end

  // The level only flips after an unbroken run of disagreeing samples; any agreement restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_evt = db_level & ~db_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      pend_br     <= 1'b0;
      pend_tgt    <= '0;
      issue_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!halt_req && (step_evt || run_en)) state <= S_ISSUE;
        end
        S_ISSUE: begin
          issue_count <= issue_count + 16'd1;
          pend_br     <= 1'b0;
          to_cnt      <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // Retirement takes priority over a timeout landing on the same cycle.
          if (exec_done) begin
            pend_br  <= branch_req;
            pend_tgt <= branch_target;
            to_cnt   <= '0;
            state    <= (branch_req && (branch_target[1:0] != 2'b00)) ? S_FAULT : S_IDLE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
            state  <= S_FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign nxt         = (state == S_ISSUE);
  assign override_en = nxt & pend_br;
  assign override_pc = nxt ? pend_tgt : '0;
  assign busy        = (state == S_ISSUE) || (state == S_WAIT);
  assign fault       = (state == S_FAULT);

endmodule
